// File: rtl/pipelined_adder.sv
// Pipelined signed N-bit adder/subtractor. The carry chain is cut into STAGES
// chunks of W bits; each stage resolves one chunk and forwards the finished lower
// sum, the pending operands and its chunk carry. Valid/ready handshakes on both sides.
module pipelined_adder #(
    parameter int unsigned N      = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ovf
);

    localparam int unsigned W = N / STAGES;
    localparam int unsigned L = STAGES - 1;

    logic en;
    logic accept;

    // Per-stage registers. Full operand words travel with the data so the final
    // stage still holds the sign bits needed for overflow.
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      a_d   [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic [N-1:0]      b_d   [STAGES];
    logic [N-1:0]      sum_q [STAGES];
    logic [N-1:0]      sum_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] vld_q, vld_d;

    // Stage inputs: index 0 comes from the ports, index k from stage k-1.
    logic [N-1:0]      a_s   [STAGES];
    logic [N-1:0]      b_s   [STAGES];
    logic [N-1:0]      sum_s [STAGES];
    logic [STAGES-1:0] c_s;
    logic [STAGES-1:0] vld_s;

    // Single advance enable; stalls the whole pipe, bubbles included.
    assign en       = !vld_q[L] || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    assign a_s[0]   = A;
    assign b_s[0]   = sub ? ~B : B;
    assign c_s[0]   = sub ? 1'b1 : ci;
    assign sum_s[0] = '0;
    assign vld_s[0] = accept;

    for (genvar g = 0; g < STAGES - 1; g++) begin : g_chain
        assign a_s[g+1]   = a_q[g];
        assign b_s[g+1]   = b_q[g];
        assign sum_s[g+1] = sum_q[g];
        assign c_s[g+1]   = c_q[g];
        assign vld_s[g+1] = vld_q[g];
    end

    // Each stage adds its own chunk and inserts it into the forwarded partial sum.
    always_comb begin
        logic [W:0] part;
        part  = '0;
        c_d   = '0;
        vld_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_s[k][k*W +: W]} + {1'b0, b_s[k][k*W +: W]} + {{W{1'b0}}, c_s[k]};
            sum_d[k]             = sum_s[k];
            sum_d[k][k*W +: W]   = part[W-1:0];
            c_d[k]               = part[W];
            a_d[k]               = a_s[k];
            b_d[k]               = b_s[k];
            vld_d[k]             = vld_s[k];
        end
    end

    // Pipeline registers: synchronous clear, hold everything while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            c_q   <= '0;
            vld_q <= '0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
            c_q   <= c_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[L];
    assign S         = sum_q[L];
    assign co        = c_q[L];
    assign ovf       = (a_q[L][N-1] == b_q[L][N-1]) && (sum_q[L][N-1] != a_q[L][N-1]);

    // Only the sign bits of the last stage's operands are needed.
    logic unused_low_bits;
    assign unused_low_bits = ^{a_q[L][N-2:0], b_q[L][N-2:0]};

endmodule
